// File: rtl/fwd_pkg.sv
// Shared definitions for the EX-stage operand forwarding logic.
// Provides the operand-mux select encoding and the pipeline shadow-slot
// types so every operand-mux user decodes selects identically.
package fwd_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned CNT_W = 32;

    typedef logic [SEL_W-1:0] sel_t;

    localparam sel_t SEL_RF   = 2'b00;
    localparam sel_t SEL_WB   = 2'b01;
    localparam sel_t SEL_MEM  = 2'b10;
    localparam sel_t SEL_ZERO = 2'b11;

    // EX shadow slot: needs sources for forwarding and memread for load-use
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic             regwrite;
        logic             memread;
    } ex_slot_t;

    // MEM/WB shadow slot: only the write-back identity matters downstream
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             regwrite;
    } ret_slot_t;

endpackage

// File: rtl/fwd_sel.sv
// Per-operand forwarding priority compare.
// Ports:
//   ex_valid            EX slot holds a real instruction
//   rs                  EX source register index for this operand
//   mem_valid/regwrite/rd  MEM slot write-back identity
//   wb_valid/regwrite/rd   WB slot write-back identity
//   sel                 operand mux select (combinational)
module fwd_sel
    import fwd_pkg::*;
(
    input  logic             ex_valid,
    input  logic [REG_W-1:0] rs,
    input  logic             mem_valid,
    input  logic             mem_regwrite,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             wb_valid,
    input  logic             wb_regwrite,
    input  logic [REG_W-1:0] wb_rd,
    output sel_t             sel
);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = mem_valid && mem_regwrite && (mem_rd == rs);
    assign wb_hit  = wb_valid  && wb_regwrite  && (wb_rd  == rs);

    // x0 reads as constant zero; the younger MEM result beats WB
    always_comb begin
        sel = SEL_RF;
        if (!ex_valid) begin
            sel = SEL_RF;
        end else if (rs == REG_W'(0)) begin
            sel = SEL_ZERO;
        end else if (mem_hit) begin
            sel = SEL_MEM;
        end else if (wb_hit) begin
            sel = SEL_WB;
        end
    end

endmodule

// File: rtl/forward_ctrl.sv
// Pipeline forwarding and load-use hazard controller.
// Tracks EX/MEM/WB shadow slots and produces EX operand-mux selects plus
// a load-use stall request.
// Ports:
//   clk_i, rst_i (async, active-low)
//   id_valid_i, id_rs1_i, id_rs2_i, id_rd_i, id_regwrite_i, id_memread_i
//   hold_i   freeze all slots
//   flush_i  discard the ID instruction (EX gets a bubble)
//   fwd_a_o, fwd_b_o  operand select codes (combinational from slots)
//   stall_o           load-use stall request (combinational)
//   stall_cnt_o       stall cycle counter, only with FWD_STALL_CNT_EN defined
module forward_ctrl
    import fwd_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_valid_i,
    input  logic [REG_W-1:0] id_rs1_i,
    input  logic [REG_W-1:0] id_rs2_i,
    input  logic [REG_W-1:0] id_rd_i,
    input  logic             id_regwrite_i,
    input  logic             id_memread_i,
    input  logic             hold_i,
    input  logic             flush_i,
    output logic [SEL_W-1:0] fwd_a_o,
    output logic [SEL_W-1:0] fwd_b_o,
    output logic             stall_o
`ifdef FWD_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt_o
`endif
);

    ex_slot_t  ex_q;
    ret_slot_t mem_q;
    ret_slot_t wb_q;
    ex_slot_t  id_slot;
    sel_t      sel_a;
    sel_t      sel_b;

    // Pack the ID-stage inputs into the EX slot shape
    always_comb begin
        id_slot          = '0;
        id_slot.valid    = id_valid_i;
        id_slot.rs1      = id_rs1_i;
        id_slot.rs2      = id_rs2_i;
        id_slot.rd       = id_rd_i;
        id_slot.regwrite = id_regwrite_i;
        id_slot.memread  = id_memread_i;
    end

    // Load in EX whose result the ID instruction needs next cycle
    assign stall_o = id_valid_i && ex_q.valid && ex_q.memread &&
                     (ex_q.rd != REG_W'(0)) &&
                     ((ex_q.rd == id_rs1_i) || (ex_q.rd == id_rs2_i));

    // Slot pipeline: hold beats flush beats stall; MEM/WB always advance
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!hold_i) begin
            ex_q           <= (flush_i || stall_o) ? '0 : id_slot;
            mem_q.valid    <= ex_q.valid;
            mem_q.rd       <= ex_q.rd;
            mem_q.regwrite <= ex_q.regwrite;
            wb_q           <= mem_q;
        end
    end

    fwd_sel u_sel_a (
        .ex_valid     (ex_q.valid),
        .rs           (ex_q.rs1),
        .mem_valid    (mem_q.valid),
        .mem_regwrite (mem_q.regwrite),
        .mem_rd       (mem_q.rd),
        .wb_valid     (wb_q.valid),
        .wb_regwrite  (wb_q.regwrite),
        .wb_rd        (wb_q.rd),
        .sel          (sel_a)
    );

    fwd_sel u_sel_b (
        .ex_valid     (ex_q.valid),
        .rs           (ex_q.rs2),
        .mem_valid    (mem_q.valid),
        .mem_regwrite (mem_q.regwrite),
        .mem_rd       (mem_q.rd),
        .wb_valid     (wb_q.valid),
        .wb_regwrite  (wb_q.regwrite),
        .wb_rd        (wb_q.rd),
        .sel          (sel_b)
    );

    assign fwd_a_o = sel_a;
    assign fwd_b_o = sel_b;

`ifdef FWD_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;

    // Saturating count of cycles actually lost to load-use stalls
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
        end else if (!hold_i && stall_o && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_forward_ctrl.sv
// Directed self-checking bench for forward_ctrl.
module tb_forward_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       id_valid_i;
    logic [4:0] id_rs1_i;
    logic [4:0] id_rs2_i;
    logic [4:0] id_rd_i;
    logic       id_regwrite_i;
    logic       id_memread_i;
    logic       hold_i;
    logic       flush_i;
    logic [1:0] fwd_a_o;
    logic [1:0] fwd_b_o;
    logic       stall_o;
`ifdef FWD_STALL_CNT_EN
    logic [31:0] stall_cnt_o;
`endif

    int errors = 0;
    int checks = 0;

    forward_ctrl dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .id_valid_i    (id_valid_i),
        .id_rs1_i      (id_rs1_i),
        .id_rs2_i      (id_rs2_i),
        .id_rd_i       (id_rd_i),
        .id_regwrite_i (id_regwrite_i),
        .id_memread_i  (id_memread_i),
        .hold_i        (hold_i),
        .flush_i       (flush_i),
        .fwd_a_o       (fwd_a_o),
        .fwd_b_o       (fwd_b_o),
        .stall_o       (stall_o)
`ifdef FWD_STALL_CNT_EN
        ,
        .stall_cnt_o   (stall_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic rw, input logic mr);
        id_valid_i    = v;
        id_rs1_i      = rs1;
        id_rs2_i      = rs2;
        id_rd_i       = rd;
        id_regwrite_i = rw;
        id_memread_i  = mr;
    endtask

    // Advance one edge; leave time just past it so inputs can be redriven
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drain();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        repeat (3) tick();
    endtask

    initial begin
        rst_i   = 1'b0;
        hold_i  = 1'b0;
        flush_i = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        #3;
        check("reset_fwd_a", 32'(fwd_a_o), 32'h0);
        check("reset_fwd_b", 32'(fwd_b_o), 32'h0);
        check("reset_stall", 32'(stall_o), 32'h0);
        tick();
        rst_i = 1'b1;
        tick();

        // Back-to-back: add x5 then sub x8,x5,x6
        set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd5, 5'd6, 5'd8, 1'b1, 1'b0);
        tick();
        #1;
        check("b2b_fwd_a", 32'(fwd_a_o), 32'h2);
        check("b2b_fwd_b", 32'(fwd_b_o), 32'h0);
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        #1;
        // Invalid EX with rs fields 0 must give 00, not 11
        check("bubble_fwd_a", 32'(fwd_a_o), 32'h0);
        drain();

        // Distance two: write x7, unrelated, read rs2=x7
        set_id(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd3, 5'd4, 5'd10, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd11, 5'd7, 5'd12, 1'b1, 1'b0);
        tick();
        #1;
        check("dist2_fwd_b", 32'(fwd_b_o), 32'h1);
        check("dist2_fwd_a", 32'(fwd_a_o), 32'h0);
        // x7 in both MEM and WB: MEM wins
        set_id(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd11, 5'd7, 5'd12, 1'b1, 1'b0);
        tick();
        #1;
        check("prio_mem_fwd_b", 32'(fwd_b_o), 32'h2);
        // MEM rd matches but does not write: fall back to WB
        set_id(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd1, 5'd2, 5'd7, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 5'd11, 5'd7, 5'd12, 1'b1, 1'b0);
        tick();
        #1;
        check("norw_fwd_b", 32'(fwd_b_o), 32'h1);
        drain();

        // Load-use: lw x3, then reader of x3
        set_id(1'b1, 5'd1, 5'd0, 5'd3, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd3, 5'd4, 5'd13, 1'b1, 1'b0);
        #1;
        check("lu_stall", 32'(stall_o), 32'h1);
        tick();
        #1;
        check("lu_stall_once", 32'(stall_o), 32'h0);
        check("lu_bubble_fwd_a", 32'(fwd_a_o), 32'h0);
        tick();
        #1;
        check("lu_fwd_a", 32'(fwd_a_o), 32'h1);
        drain();

        // Load-use through rs2
        set_id(1'b1, 5'd1, 5'd0, 5'd3, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd8, 5'd3, 5'd13, 1'b1, 1'b0);
        #1;
        check("lu_rs2_stall", 32'(stall_o), 32'h1);
        drain();

        // x0: load to x0, then reader of x0
        set_id(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd0, 5'd5, 5'd14, 1'b1, 1'b0);
        #1;
        check("x0_stall", 32'(stall_o), 32'h0);
        tick();
        #1;
        check("x0_fwd_a", 32'(fwd_a_o), 32'h3);
        check("x0_fwd_b", 32'(fwd_b_o), 32'h0);
        drain();

        // Priority: hold over flush/stall, then flush with stall
        set_id(1'b1, 5'd1, 5'd2, 5'd20, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd20, 5'd0, 5'd3, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd3, 5'd20, 5'd21, 1'b1, 1'b0);
        hold_i  = 1'b1;
        flush_i = 1'b1;
        repeat (3) tick();
        #1;
        check("hold_fwd_a", 32'(fwd_a_o), 32'h2);
        check("hold_fwd_b", 32'(fwd_b_o), 32'h3);
        check("hold_stall", 32'(stall_o), 32'h1);
        hold_i = 1'b0;
        tick();
        flush_i = 1'b0;
        #1;
        check("flush_fwd_a", 32'(fwd_a_o), 32'h0);
        check("flush_fwd_b", 32'(fwd_b_o), 32'h0);
        check("flush_stall", 32'(stall_o), 32'h0);
        drain();

        // Reset mid-stream with MEM holding x9 and a stall pending
        set_id(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd9, 5'd0, 5'd4, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd4, 5'd0, 5'd15, 1'b1, 1'b0);
        #1;
        check("pre_rst_fwd_a", 32'(fwd_a_o), 32'h2);
        check("pre_rst_stall", 32'(stall_o), 32'h1);
        rst_i = 1'b0;
        #1;
        check("rst_fwd_a", 32'(fwd_a_o), 32'h0);
        check("rst_fwd_b", 32'(fwd_b_o), 32'h0);
        check("rst_stall", 32'(stall_o), 32'h0);
        set_id(1'b1, 5'd9, 5'd9, 5'd16, 1'b1, 1'b0);
        tick();
        rst_i = 1'b1;
        tick();
        #1;
        check("post_rst_fwd_a", 32'(fwd_a_o), 32'h0);
        check("post_rst_fwd_b", 32'(fwd_b_o), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/forward_ctrl.md
FORWARD_CTRL -- requirements
Module: forward_ctrl

Interface
REQ-001 SHALL have clk_i, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have rst_i, input, 1, asynchronous, active-low reset.
REQ-003 SHALL have id_valid_i, input, 1, the ID-stage slot holds a real instruction.
REQ-004 SHALL have id_rs1_i and id_rs2_i, input, 5 each, ID-stage source register indices.
REQ-005 SHALL have id_rd_i, input, 5, ID-stage destination index.
REQ-006 SHALL have id_regwrite_i and id_memread_i, input, 1 each, ID-stage writes rd / is a load.
REQ-007 SHALL have hold_i, input, 1, global freeze (memory wait); all state holds.
REQ-008 SHALL have flush_i, input, 1, taken branch; the ID instruction is discarded.
REQ-009 SHALL have fwd_a_o and fwd_b_o, output, 2 each, select codes for the EX-stage 4:1 operand muxes.
REQ-010 SHALL have stall_o, output, 1, load-use stall request to the PC and IF/ID registers.

Function
REQ-011 SHALL keep shadow slots EX {valid, rs1, rs2, rd, regwrite, memread}, MEM {valid, rd, regwrite} and WB {valid, rd, regwrite}.
REQ-012 SHALL use select encoding 2'b00 register-file value, 2'b01 WB result, 2'b10 MEM ALU result, 2'b11 constant zero.
REQ-013 SHALL drive fwd_a_o from EX.rs1, combinationally from slot state only, as follows: 11 if rs1==0; else 10 if MEM.valid && MEM.regwrite && MEM.rd==rs1; else 01 if the same match holds on WB; else 00.
REQ-014 SHALL drive fwd_b_o identically from EX.rs2.
REQ-015 SHALL give MEM priority over WB when both match.
REQ-016 SHALL force fwd_a_o and fwd_b_o to 00 when EX.valid is 0.
REQ-017 SHALL assert stall_o combinationally when all of the following hold: id_valid_i && EX.valid && EX.memread && EX.rd!=0 && (EX.rd==id_rs1_i || EX.rd==id_rs2_i).
REQ-018 SHALL, on each clock edge with hold_i=0 and no stall or flush, shift ID inputs into EX, EX into MEM, and MEM into WB.
REQ-019 SHALL, on each clock edge with hold_i=0 and stall_o=1, load a bubble (valid=0, all other fields 0) into EX while MEM and WB still advance.
REQ-020 SHALL, on each clock edge with hold_i=0 and flush_i=1, load a bubble into EX; flush_i has priority over stall_o.
REQ-021 SHALL, when hold_i=1, hold every slot unchanged; hold_i has priority over flush_i and stall_o, and stall_o stays combinationally valid during the hold.
REQ-022 SHALL have a latency of one cycle from ID capture to the forwarding decision in EX, with zero additional latency on outputs.

Reset
REQ-023 SHALL, while rst_i=0, immediately clear all slots (valid=0, all other fields 0), giving fwd_a_o=fwd_b_o=00 and stall_o=0.
REQ-024 SHALL discard all in-flight slots on reset asserted mid-operation; the first post-reset instruction sees no stale forwarding.

Configuration
REQ-025 SHALL, when FWD_STALL_CNT_EN is defined, add output stall_cnt_o (32 bits), which increments on every clock edge with hold_i=0 and stall_o=1, saturates at 32'hFFFF_FFFF and resets to 0.
REQ-026 SHALL, when FWD_STALL_CNT_EN is undefined, omit both the port and the counter logic, with all other behaviour identical.

Structure
REQ-027 SHALL place the select-code constants (SEL_RF, SEL_WB, SEL_MEM, SEL_ZERO) and the slot struct typedef in shared package fwd_pkg, so the operand-mux users share the same encoding.
REQ-028 SHALL implement the per-operand priority compare as sub-module fwd_sel, instantiated twice (operand A and operand B).

Verification
REQ-029 SHALL test back-to-back dependency: add x5 in ID, then next cycle sub with rs1=x5 -> in the cycle sub is in EX, fwd_a_o=10 and fwd_b_o=00.
REQ-030 SHALL test distance-two dependency: write x7, one unrelated instruction, then read rs2=x7 -> fwd_b_o=01; with x7 written in both MEM and WB -> fwd_b_o=10.
REQ-031 SHALL test load-use: lw x3 in EX, ID reads rs1=x3 -> stall_o=1 for exactly one cycle, EX bubble next cycle, then fwd_a_o=01 when the dependent instruction reaches EX.
REQ-032 SHALL test x0: a writer with rd=0 followed by a reader with rs1=0 -> fwd_a_o=11, stall_o=0 even when the writer is a load.
REQ-033 SHALL test priority: hold_i=1 with flush_i=1 for 3 cycles -> slots unchanged; release with flush_i=1 and stall_o=1 -> EX bubble and ID not captured.
REQ-034 SHALL test reset: rst_i low mid-stream with MEM holding x9 -> outputs 00/00/0 immediately; after release, a reader of x9 gets 00.
